// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one multi-cycle ALU between two requesters.
// One operation in flight at a time. The arbitration is round-robin between the two requesters.
// A wait counter aborts the operation when alu_done does not arrive within TIMEOUT WAIT cycles.
module alu_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [31:0] req0_op1,
    input  logic [31:0] req1_op1,
    input  logic [31:0] req0_op2,
    input  logic [31:0] req1_op2,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    input  logic        rsp0_ready,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic        alu_start,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    input  logic        alu_done,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_flags,
    output logic        timeout_err
);

    // The counter holds the number of WAIT cycles already spent (0..TIMEOUT-1).
    // The timeout fires in the cycle where that count would reach TIMEOUT.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [31:0]      op1_reg, op2_reg;
    logic [31:0]      rsp_result_reg;
    logic [3:0]       rsp_flags_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             grant_reg;      // requester owning the current operation
    logic             last_reg;       // requester served most recently
    logic             timeout_err_reg;

    logic [1:0] req_valid;
    logic [1:0] rsp_ready;
    logic [1:0] req_ready_vec;
    logic [1:0] rsp_valid_vec;
    logic       any_req;
    logic       winner;
    logic       grant_fire;
    logic       rsp_fire;
    logic       cnt_expired;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};
    assign any_req   = |req_valid;
    // On contention the requester not served last wins; otherwise the lone requester wins.
    assign winner      = (req_valid == 2'b11) ? ~last_reg : req_valid[1];
    // Ready is gated by rst so nothing is accepted while reset is held.
    assign grant_fire  = (state_reg == IDLE) && any_req && !rst;
    assign rsp_fire    = (state_reg == RESP) && rsp_ready[grant_reg];
    assign cnt_expired = (cnt_reg == CNT_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; alu_done outside WAIT has no effect
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (any_req) state_next = ISSUE;
            ISSUE: state_next = WAIT;
            WAIT:  if (alu_done || cnt_expired) state_next = RESP;
            RESP:  if (rsp_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: per-requester handshakes and the ALU launch pulse
    always_comb begin
        alu_start = (state_reg == ISSUE);
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign req_ready_vec[gi] = grant_fire && (winner == gi[0]);
        assign rsp_valid_vec[gi] = (state_reg == RESP) && (grant_reg == gi[0]);
    end

    assign req0_ready  = req_ready_vec[0];
    assign req1_ready  = req_ready_vec[1];
    assign rsp0_valid  = rsp_valid_vec[0];
    assign rsp1_valid  = rsp_valid_vec[1];
    assign alu_op1     = op1_reg;
    assign alu_op2     = op2_reg;
    assign rsp_result  = rsp_result_reg;
    assign rsp_flags   = rsp_flags_reg;
    assign timeout_err = timeout_err_reg;

    // Datapath: operand capture, wait counter, response capture, round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op1_reg         <= '0;
            op2_reg         <= '0;
            rsp_result_reg  <= '0;
            rsp_flags_reg   <= '0;
            cnt_reg         <= '0;
            grant_reg       <= 1'b0;
            last_reg        <= 1'b1;   // makes requester 0 win the first contention
            timeout_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        op1_reg   <= winner ? req1_op1 : req0_op1;
                        op2_reg   <= winner ? req1_op2 : req0_op2;
                        grant_reg <= winner;
                    end
                end
                ISSUE: begin
                    cnt_reg <= '0;
                end
                WAIT: begin
                    // A done arriving on the last allowed cycle beats the timeout
                    if (alu_done) begin
                        rsp_result_reg <= alu_result;
                        rsp_flags_reg  <= alu_flags;
                    end else if (cnt_expired) begin
                        rsp_result_reg  <= '0;
                        rsp_flags_reg   <= '0;
                        timeout_err_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_fire) last_reg <= grant_reg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter (TIMEOUT=4): directed table, reset-in-WAIT
// sequence, then randomized operations against a transaction-level model.
module tb_alu_arbiter;

    localparam int TMO = 4;

    logic        clk, rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_op1, req1_op1, req0_op2, req1_op2;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        alu_start;
    logic [31:0] alu_op1, alu_op2;
    logic        alu_done;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic        timeout_err;

    int n_cmp = 0;
    int n_bad = 0;
    int op_no = 0;

    alu_arbiter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_op1(req0_op1), .req1_op1(req1_op1),
        .req0_op2(req0_op2), .req1_op2(req1_op2),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .alu_start(alu_start), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_done(alu_done), .alu_result(alu_result), .alu_flags(alu_flags),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        v0, v1;
        logic [31:0] a0, b0, a1, b1;
        int          delay, bp;
        logic        stray;
        int          g;
        logic [31:0] alu_res;
        logic [3:0]  alu_flg;
        logic [31:0] exp_res;
        logic [3:0]  exp_flg;
        logic        exp_tmo;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (op %0d): got %h expected %h", name, op_no, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One complete operation: IDLE grant, ISSUE, WAIT (ALU answers in WAIT cycle
    // 'delay', never if delay > TMO), then RESP held for 'bp' cycles of backpressure.
    task automatic run_op(input logic v0, input logic v1,
                          input logic [31:0] a0, input logic [31:0] b0,
                          input logic [31:0] a1, input logic [31:0] b1,
                          input int delay, input int bp, input logic stray, input int g,
                          input logic [31:0] ares, input logic [3:0] aflg,
                          input logic [31:0] exp_res, input logic [3:0] exp_flg,
                          input logic exp_tmo);
        logic [31:0] x1, x2;
        int wait_len;
        x1 = (g == 1) ? a1 : a0;
        x2 = (g == 1) ? b1 : b0;
        wait_len = (delay <= TMO) ? delay : TMO;
        // IDLE: grant expected in this very cycle
        req0_valid = v0; req1_valid = v1;
        req0_op1 = a0; req0_op2 = b0; req1_op1 = a1; req1_op2 = b1;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        alu_done = stray; alu_result = $urandom; alu_flags = 4'($urandom);
        @(negedge clk);
        check("req0_ready_grant", req0_ready, g == 0);
        check("req1_ready_grant", req1_ready, g == 1);
        check("alu_start_idle", alu_start, 0);
        check("rsp_valid_idle", {rsp1_valid, rsp0_valid}, 0);
        next_cycle();
        // ISSUE
        alu_done = stray;
        @(negedge clk);
        check("alu_start_issue", alu_start, 1);
        check("alu_op1_issue", alu_op1, x1);
        check("alu_op2_issue", alu_op2, x2);
        check("ready_issue", {req1_ready, req0_ready}, 0);
        next_cycle();
        // WAIT
        for (int k = 1; k <= wait_len; k++) begin
            alu_done   = (k == delay);
            alu_result = (k == delay) ? ares : $urandom;
            alu_flags  = (k == delay) ? aflg : 4'($urandom);
            @(negedge clk);
            check("alu_start_wait", alu_start, 0);
            check("alu_op1_wait", alu_op1, x1);
            check("alu_op2_wait", alu_op2, x2);
            check("rsp_valid_wait", {rsp1_valid, rsp0_valid}, 0);
            check("ready_wait", {req1_ready, req0_ready}, 0);
            next_cycle();
        end
        // RESP with backpressure; stray alu_done pulses must not disturb it
        for (int k = 0; k <= bp; k++) begin
            alu_done = 1'($urandom_range(0, 1));
            alu_result = $urandom; alu_flags = 4'($urandom);
            if (g == 0) begin
                rsp0_ready = (k == bp); rsp1_ready = 1'($urandom_range(0, 1));
            end else begin
                rsp1_ready = (k == bp); rsp0_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            check("rsp0_valid", rsp0_valid, g == 0);
            check("rsp1_valid", rsp1_valid, g == 1);
            check("rsp_result", rsp_result, exp_res);
            check("rsp_flags", rsp_flags, exp_flg);
            check("timeout_err", timeout_err, exp_tmo);
            check("alu_start_resp", alu_start, 0);
            check("ready_resp", {req1_ready, req0_ready}, 0);
            next_cycle();
        end
        alu_done = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        $display("op %0d: grant=%0d delay=%0d bp=%0d result=%h flags=%h timeout_err=%0b",
                 op_no, g, delay, bp, exp_res, exp_flg, exp_tmo);
        op_no++;
    endtask

    int          last_served;
    logic        tmo_model;
    logic [1:0]  v;
    logic [31:0] ra0, rb0, ra1, rb1, x1, x2;
    int          rdelay, rbp, rg;
    logic        timed;

    initial begin
        //           v0 v1 a0            b0            a1            b1            dly bp stray g alu_res       flg    exp_res       exp_flg tmo
        vecs[0] = '{1, 1, 32'h00000011, 32'h00000022, 32'h00000033, 32'h00000044, 1, 0, 0, 0, 32'h00000033, 4'h1, 32'h00000033, 4'h1, 0};
        vecs[1] = '{1, 1, 32'h00000011, 32'h00000022, 32'h00000033, 32'h00000044, 3, 1, 1, 1, 32'h00000077, 4'h2, 32'h00000077, 4'h2, 0};
        vecs[2] = '{1, 1, 32'hFFFFFFFF, 32'h00000001, 32'h80000000, 32'h80000000, 2, 0, 0, 0, 32'h00000000, 4'h4, 32'h00000000, 4'h4, 0};
        vecs[3] = '{1, 1, 32'hFFFFFFFF, 32'h00000001, 32'h80000000, 32'h80000000, 1, 2, 0, 1, 32'h00000000, 4'h3, 32'h00000000, 4'h3, 0};
        vecs[4] = '{1, 0, 32'h00000005, 32'h00000003, 32'h00000000, 32'h00000000, 2, 0, 0, 0, 32'h00000008, 4'h0, 32'h00000008, 4'h0, 0};
        vecs[5] = '{0, 1, 32'h00000000, 32'h00000000, 32'h12345678, 32'h11111111, 1, 10, 0, 1, 32'h23456789, 4'h8, 32'h23456789, 4'h8, 0};
        vecs[6] = '{1, 1, 32'h00000100, 32'h00000200, 32'h00000300, 32'h00000400, 4, 0, 0, 0, 32'h00000300, 4'h9, 32'h00000300, 4'h9, 0};
        vecs[7] = '{0, 1, 32'h00000000, 32'h00000000, 32'hAAAA0000, 32'h00005555, 9, 1, 0, 1, 32'hFFFFFFFF, 4'hF, 32'h00000000, 4'h0, 1};
        vecs[8] = '{1, 1, 32'h00000007, 32'h00000008, 32'h00000009, 32'h0000000A, 1, 0, 1, 0, 32'h0000000F, 4'h1, 32'h0000000F, 4'h1, 1};
        vecs[9] = '{1, 1, 32'h00000007, 32'h00000008, 32'h00000009, 32'h0000000A, 2, 0, 0, 1, 32'h00000013, 4'h2, 32'h00000013, 4'h2, 1};

        // Reset with both requesters asserting: nothing may be accepted
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op1 = 32'h1; req0_op2 = 32'h2; req1_op1 = 32'h3; req1_op2 = 32'h4;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        alu_done = 1'b1; alu_result = 32'hFFFFFFFF; alu_flags = 4'hF;
        next_cycle();
        @(negedge clk);
        check("rst_ready", {req1_ready, req0_ready}, 0);
        check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        check("rst_alu_start", alu_start, 0);
        check("rst_alu_op1", alu_op1, 0);
        check("rst_alu_op2", alu_op2, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_flags", rsp_flags, 0);
        check("rst_timeout_err", timeout_err, 0);
        next_cycle();
        rst = 1'b0;

        // Directed table: contention from reset, single request, backpressure,
        // done on the last allowed cycle, timeout and its stickiness
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].v0, vecs[i].v1, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
                   vecs[i].delay, vecs[i].bp, vecs[i].stray, vecs[i].g,
                   vecs[i].alu_res, vecs[i].alu_flg, vecs[i].exp_res, vecs[i].exp_flg,
                   vecs[i].exp_tmo);
        end

        // Reset two cycles after alu_start, followed by a late alu_done
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_op1 = 32'hCAFE0000; req0_op2 = 32'h0000BABE;
        @(negedge clk);
        check("rw_grant", req0_ready, 1);
        next_cycle();
        @(negedge clk);
        check("rw_alu_start", alu_start, 1);
        next_cycle();
        next_cycle();
        rst = 1'b1;
        #1;
        @(negedge clk);
        check("rw_ready", {req1_ready, req0_ready}, 0);
        check("rw_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        check("rw_alu_op1", alu_op1, 0);
        check("rw_alu_op2", alu_op2, 0);
        check("rw_rsp_result", rsp_result, 0);
        check("rw_timeout_err", timeout_err, 0);
        next_cycle();
        rst = 1'b0; req0_valid = 1'b0; alu_done = 1'b1;
        alu_result = 32'h5A5A5A5A; alu_flags = 4'hA;
        @(negedge clk);
        check("rw_late_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        check("rw_late_alu_start", alu_start, 0);
        next_cycle();
        alu_done = 1'b0;
        @(negedge clk);
        check("rw_idle_alu_start", alu_start, 0);
        check("rw_idle_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        next_cycle();
        last_served = 1;
        tmo_model = 1'b0;
        run_op(1, 0, 32'h00000020, 32'h00000022, 32'h0, 32'h0, 2, 0, 0, 0,
               32'h00000042, 4'h0, 32'h00000042, 4'h0, 0);
        last_served = 0;

        // Randomized operations checked against the transaction-level model
        for (int i = 0; i < 40; i++) begin
            v = 2'($urandom_range(1, 3));
            ra0 = $urandom; rb0 = $urandom; ra1 = $urandom; rb1 = $urandom;
            rdelay = $urandom_range(1, 6);
            rbp = $urandom_range(0, 3);
            if (v == 2'b11) rg = (last_served == 0) ? 1 : 0;
            else            rg = v[1] ? 1 : 0;
            x1 = (rg == 1) ? ra1 : ra0;
            x2 = (rg == 1) ? rb1 : rb0;
            timed = (rdelay > TMO);
            tmo_model = tmo_model | timed;
            run_op(v[0], v[1], ra0, rb0, ra1, rb1, rdelay, rbp, 1'($urandom_range(0, 1)), rg,
                   x1 + x2, x1[3:0] ^ x2[3:0],
                   timed ? 32'h0 : x1 + x2, timed ? 4'h0 : (x1[3:0] ^ x2[3:0]),
                   tmo_model);
            last_served = rg;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
